uart_tx_arbiter: RTL

//  Shares the single UART tx serializer between NREQ byte producers (e.g. CPU store port, debug dumper).

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx serializer among NREQ byte producers, one byte per frame.
// Optional WAIT_BUSY timeout (adds timeout_err) when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_wr_en,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [1:0]        grant_id,
  output logic              arb_busy,
`ifdef UART_TX_ARB_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [1:0] rr_ptr;
  logic [1:0] win_idx;
  logic [7:0] win_byte;
  logic       win_found;
  logic       accept;
  int         best_d;
  int         d;

  // Winner = valid requester with the smallest distance after rr_ptr (wrapping).
  always_comb begin
    best_d   = NREQ;
    d        = 0;
    win_idx  = '0;
    win_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        d = (i + 2 * NREQ - 1 - int'(rr_ptr)) % NREQ;
        if (d < best_d) begin
          best_d   = d;
          win_idx  = 2'(i);
          win_byte = req_data[8*i +: 8];
        end
      end
    end
    win_found = (best_d < NREQ);
  end

  // Handshake: a byte moves at a rising edge where req_valid[i] & req_ready[i]; ready is offered
  // only in IDLE with tx_busy low, to the winner alone, and a requester may drop valid at any time.
  assign accept = (state == IDLE) && !tx_busy && win_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (win_idx == 2'(i));
    end
  end

  assign tx_wr_en  = (state == LAUNCH);
  assign arb_busy  = (state != IDLE);
  assign dbg_state = state;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       wait_expired;

  // wait_cnt == 254 marks the 255th cycle spent in WAIT_BUSY.
  assign wait_expired = (state == WAIT_BUSY) && !tx_busy && (wait_cnt == 8'd254);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wait_expired;
      if (state == LAUNCH) begin
        wait_cnt <= '0;
      end else if (state == WAIT_BUSY) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = LAUNCH;
      end
      LAUNCH: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (wait_expired) begin
          state_next = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      grant_id <= 2'd0;
      rr_ptr   <= 2'(NREQ - 1);
    end else begin
      state <= state_next;
      if (accept) begin
        tx_data  <= win_byte;
        grant_id <= win_idx;
        rr_ptr   <= win_idx;
      end
    end
  end

endmodule
